// File: rtl/aes_sbox_lane_arbiter.sv
// aes_sbox_lane_arbiter
// Shares one 32-bit S-box lane (four external combinational S-boxes) between
// a 128-bit SubBytes job (four lane cycles) and a 32-bit SubWord job (one lane
// cycle). SubWord either always wins (PRIO_SW=1) or alternates with SubBytes.
module aes_sbox_lane_arbiter #(
    parameter bit PRIO_SW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sb_req_valid,
    output logic         sb_req_ready,
    input  logic [127:0] sb_state_in,
    output logic         sb_resp_valid,
    output logic [127:0] sb_state_out,
    input  logic         sw_req_valid,
    output logic         sw_req_ready,
    input  logic [31:0]  sw_word_in,
    output logic         sw_resp_valid,
    output logic [31:0]  sw_word_out,
    output logic [31:0]  lane_in,
    input  logic [31:0]  lane_out,
    output logic         busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Identity of the last lane user, for round-robin alternation.
    localparam logic OWN_SB = 1'b0;
    localparam logic OWN_SW = 1'b1;

    state_t       state_r;
    logic [1:0]   word_cnt_r;
    logic         rr_last_r;
    logic [127:0] in_buf_r;
    logic [95:0]  out_buf_r;   // words 0..2 of the result; word 3 comes straight off the lane

    logic         sw_own_s;
    logic         sb_own_s;
    logic [31:0]  sb_word_s;

    // Decide who owns the lane this cycle and steer the matching word onto it.
    always_comb begin
        sw_own_s  = 1'b0;
        sb_own_s  = 1'b0;
        sb_word_s = 32'h0000_0000;
        lane_in   = 32'h0000_0000;

        case (word_cnt_r)
            2'd0:    sb_word_s = in_buf_r[127:96];
            2'd1:    sb_word_s = in_buf_r[95:64];
            2'd2:    sb_word_s = in_buf_r[63:32];
            default: sb_word_s = in_buf_r[31:0];
        endcase

        // Nobody is granted while reset is held, so no lane traffic leaks out.
        if (rst) begin
            sw_own_s = 1'b0;
            sb_own_s = 1'b0;
        end else if (sw_req_valid &&
                     ((state_r == ST_IDLE) || (PRIO_SW == 1'b1) || (rr_last_r == OWN_SB))) begin
            sw_own_s = 1'b1;
        end else if (state_r == ST_RUN) begin
            sb_own_s = 1'b1;
        end else begin
            sw_own_s = 1'b0;
            sb_own_s = 1'b0;
        end

        if (sw_own_s) begin
            lane_in = sw_word_in;
        end else if (sb_own_s) begin
            lane_in = sb_word_s;
        end else begin
            lane_in = 32'h0000_0000;
        end
    end

    assign sw_req_ready = sw_own_s;
    assign sb_req_ready = (state_r == ST_IDLE) && !rst;
    assign busy         = (state_r == ST_RUN);

    // SubBytes sequencing FSM, round-robin history and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            word_cnt_r    <= 2'd0;
            rr_last_r     <= OWN_SB;
            in_buf_r      <= 128'h0;
            out_buf_r     <= 96'h0;
            sb_resp_valid <= 1'b0;
            sb_state_out  <= 128'h0;
            sw_resp_valid <= 1'b0;
            sw_word_out   <= 32'h0000_0000;
        end else begin
            sb_resp_valid <= 1'b0;
            sw_resp_valid <= sw_own_s;

            if (sw_own_s) begin
                sw_word_out <= lane_out;
                rr_last_r   <= OWN_SW;
            end else if (sb_own_s) begin
                rr_last_r   <= OWN_SB;
            end else begin
                rr_last_r   <= rr_last_r;
            end

            case (state_r)
                ST_IDLE: begin
                    // The lane is not used by SubBytes in the accept cycle.
                    if (sb_req_valid) begin
                        in_buf_r   <= sb_state_in;
                        word_cnt_r <= 2'd0;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sb_own_s) begin
                        word_cnt_r <= word_cnt_r + 2'd1;
                        case (word_cnt_r)
                            2'd0:    out_buf_r[95:64] <= lane_out;
                            2'd1:    out_buf_r[63:32] <= lane_out;
                            2'd2:    out_buf_r[31:0]  <= lane_out;
                            default: begin
                                sb_state_out  <= {out_buf_r, lane_out};
                                sb_resp_valid <= 1'b1;
                                state_r       <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sbox_lane_arbiter.sv
// Testbench for aes_sbox_lane_arbiter. Two instances (PRIO_SW=0 and PRIO_SW=1)
// share the same requests; each has its own S-box lane computed from GF(2^8)
// arithmetic. A transaction-level reference tracks each instance.
module tb_aes_sbox_lane_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         sb_req_valid;
    logic [127:0] sb_state_in;
    logic         sw_req_valid;
    logic [31:0]  sw_word_in;

    logic         sb_req_ready_a  [2];
    logic         sb_resp_valid_a [2];
    logic [127:0] sb_state_out_a  [2];
    logic         sw_req_ready_a  [2];
    logic         sw_resp_valid_a [2];
    logic [31:0]  sw_word_out_a   [2];
    logic [31:0]  lane_in_a       [2];
    logic [31:0]  lane_out_a      [2];
    logic         busy_a          [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, b;
        logic [7:0] e;
        r = 8'h01;
        e = 8'd254;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, x);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[127-32*i -: 32] = sub_word(s[127-32*i -: 32]);
        return r;
    endfunction

    assign lane_out_a[0] = sub_word(lane_in_a[0]);
    assign lane_out_a[1] = sub_word(lane_in_a[1]);

    aes_sbox_lane_arbiter #(.PRIO_SW(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready_a[0]), .sb_state_in(sb_state_in),
        .sb_resp_valid(sb_resp_valid_a[0]), .sb_state_out(sb_state_out_a[0]),
        .sw_req_valid(sw_req_valid), .sw_req_ready(sw_req_ready_a[0]), .sw_word_in(sw_word_in),
        .sw_resp_valid(sw_resp_valid_a[0]), .sw_word_out(sw_word_out_a[0]),
        .lane_in(lane_in_a[0]), .lane_out(lane_out_a[0]), .busy(busy_a[0])
    );

    aes_sbox_lane_arbiter #(.PRIO_SW(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready_a[1]), .sb_state_in(sb_state_in),
        .sb_resp_valid(sb_resp_valid_a[1]), .sb_state_out(sb_state_out_a[1]),
        .sw_req_valid(sw_req_valid), .sw_req_ready(sw_req_ready_a[1]), .sw_word_in(sw_word_in),
        .sw_resp_valid(sw_resp_valid_a[1]), .sw_word_out(sw_word_out_a[1]),
        .lane_in(lane_in_a[1]), .lane_out(lane_out_a[1]), .busy(busy_a[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, one slot per instance
    logic         m_busy    [2];
    int           m_done    [2];
    logic [127:0] m_job     [2];
    logic         m_last_sw [2];
    logic         m_sb_due  [2];
    logic         m_sw_due  [2];
    logic [127:0] m_sb_hold [2];
    logic [31:0]  m_sw_hold [2];
    int           sb_resp_cnt   [2] = '{0, 0};
    int           last_resp_cyc [2] = '{0, 0};
    logic         m_grant;
    logic         m_was_busy;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("rst_sw_req_ready", sw_req_ready_a[d], 1'b0);
                chk("rst_lane_in", lane_in_a[d], 32'h0);
                m_busy[d] = 1'b0; m_done[d] = 0; m_job[d] = 128'h0; m_last_sw[d] = 1'b0;
                m_sb_due[d] = 1'b0; m_sw_due[d] = 1'b0; m_sb_hold[d] = 128'h0; m_sw_hold[d] = 32'h0;
            end else begin
                chk("sw_resp_valid", sw_resp_valid_a[d], m_sw_due[d]);
                chk("sw_word_out", sw_word_out_a[d], m_sw_hold[d]);
                chk("sb_resp_valid", sb_resp_valid_a[d], m_sb_due[d]);
                chk("sb_state_out", sb_state_out_a[d], m_sb_hold[d]);
                if (sb_resp_valid_a[d]) begin
                    sb_resp_cnt[d]++;
                    last_resp_cyc[d] = cyc;
                end
                chk("busy", busy_a[d], m_busy[d]);
                chk("sb_req_ready", sb_req_ready_a[d], !m_busy[d]);
                m_was_busy = m_busy[d];
                m_grant = sw_req_valid && (!m_busy[d] || (d == 1) || !m_last_sw[d]);
                chk("sw_req_ready", sw_req_ready_a[d], m_grant);
                m_sw_due[d] = m_grant;
                m_sb_due[d] = 1'b0;
                if (m_grant) begin
                    chk("lane_in_sw", lane_in_a[d], sw_word_in);
                    m_sw_hold[d] = sub_word(sw_word_in);
                    m_last_sw[d] = 1'b1;
                end else if (m_busy[d]) begin
                    chk("lane_in_sb", lane_in_a[d], m_job[d][127-32*m_done[d] -: 32]);
                    m_last_sw[d] = 1'b0;
                    m_done[d]++;
                    if (m_done[d] == 4) begin
                        m_busy[d]    = 1'b0;
                        m_sb_due[d]  = 1'b1;
                        m_sb_hold[d] = sub_state(m_job[d]);
                    end
                end else begin
                    chk("lane_in_idle", lane_in_a[d], 32'h0);
                end
                if (!m_was_busy && sb_req_valid) begin
                    m_job[d]  = sb_state_in;
                    m_busy[d] = 1'b1;
                    m_done[d] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a[0] || busy_a[1]) && n < 300) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", busy_a[0] || busy_a[1], 1'b0);
    endtask

    task automatic sb_go(input logic [127:0] s, output int acc);
        wait_idle();
        sb_req_valid = 1'b1;
        sb_state_in  = s;
        acc = cyc;
        tick();
        sb_req_valid = 1'b0;
        #1;
    endtask

    localparam logic [127:0] V2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R2   = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] R0   = 128'h63636363636363636363636363636363;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int cnt0;
        logic [127:0] v;
        logic [31:0] w;
        logic hold_sw;

        rst = 1'b1; sb_req_valid = 1'b0; sw_req_valid = 1'b0;
        sb_state_in = 128'h0; sw_word_in = 32'h0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", busy_a[d], 1'b0);
            chk("reset_sb_state_out", sb_state_out_a[d], 128'h0);
            chk("reset_sw_word_out", sw_word_out_a[d], 32'h0);
            chk("reset_sb_resp_valid", sb_resp_valid_a[d], 1'b0);
            chk("reset_sw_resp_valid", sw_resp_valid_a[d], 1'b0);
        end
        rst = 1'b0;
        tick();

        // 1: all-zero state, uncontended
        sb_go(128'h0, acc);
        repeat (6) tick();
        for (int d = 0; d < 2; d++) begin
            chk("t1_latency", last_resp_cyc[d], acc + 5);
            chk("t1_data", sb_state_out_a[d], R0);
        end

        // 2: FIPS-197 style vector, lane order
        sb_go(V2, acc);
        chk("t2_lane_first", lane_in_a[1], 32'h00010203);
        repeat (3) tick();
        chk("t2_lane_last", lane_in_a[1], 32'h0c0d0e0f);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("t2_latency", last_resp_cyc[d], acc + 5);
            chk("t2_data", sb_state_out_a[d], R2);
        end
        chk("t2_ready_again", sb_req_ready_a[1], 1'b1);

        // 3: SubWord while idle
        wait_idle();
        sw_req_valid = 1'b1; sw_word_in = 32'h00010203;
        #1;
        chk("t3_sw_ready", sw_req_ready_a[1], 1'b1);
        chk("t3_sw_ready_rr", sw_req_ready_a[0], 1'b1);
        tick();
        sw_req_valid = 1'b0;
        #1;
        chk("t3_sw_resp_valid", sw_resp_valid_a[1], 1'b1);
        chk("t3_sw_word_out", sw_word_out_a[1], 32'h637c777b);

        // 4: one SubWord during SB word 1 delays SB by one cycle
        sb_go(V2, acc);
        tick();
        sw_req_valid = 1'b1; sw_word_in = 32'h0c0d0e0f;
        #1;
        chk("t4_sw_ready", sw_req_ready_a[1], 1'b1);
        chk("t4_lane_sw", lane_in_a[1], 32'h0c0d0e0f);
        tick();
        sw_req_valid = 1'b0;
        #1;
        chk("t4_sw_word_out", sw_word_out_a[1], 32'hfed7ab76);
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            chk("t4_latency", last_resp_cyc[d], acc + 6);
            chk("t4_data", sb_state_out_a[d], R2);
        end

        // 5: SubWord held across the job: round-robin alternates, priority starves SB
        wait_idle();
        v = {$urandom, $urandom, $urandom, $urandom};
        w = 32'h3a5cc5a3;
        sw_req_valid = 1'b1; sw_word_in = w;
        sb_go(v, acc);
        for (int k = 1; k <= 7; k++) begin
            chk("t5_lane_alt", lane_in_a[0], (k % 2 == 1) ? {96'h0, v[127-32*((k-1)/2) -: 32]} : {96'h0, w});
            tick();
        end
        chk("t5_rr_resp", sb_resp_valid_a[0], 1'b1);
        chk("t5_prio_starved", busy_a[1], 1'b1);
        sw_req_valid = 1'b0;
        repeat (6) tick();
        chk("t5_rr_latency", last_resp_cyc[0], acc + 8);
        chk("t5_prio_latency", last_resp_cyc[1], acc + 12);
        chk("t5_data", sb_state_out_a[1], sub_state(v));

        // 6: reset in the middle of a job
        v = {$urandom, $urandom, $urandom, $urandom};
        sb_go(v, acc);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        cnt0 = sb_resp_cnt[1];
        for (int d = 0; d < 2; d++) begin
            chk("t6_busy", busy_a[d], 1'b0);
            chk("t6_sb_state_out", sb_state_out_a[d], 128'h0);
            chk("t6_sb_resp_valid", sb_resp_valid_a[d], 1'b0);
        end
        repeat (6) tick();
        chk("t6_no_resp", sb_resp_cnt[1], cnt0);
        sb_go(128'h0, acc);
        repeat (6) tick();
        chk("t6_after_latency", last_resp_cyc[1], acc + 5);
        chk("t6_after_data", sb_state_out_a[1], R0);

        // Randomized traffic checked by the reference model
        for (int i = 0; i < 3000; i++) begin
            hold_sw = sw_req_valid && !(sw_req_ready_a[0] && sw_req_ready_a[1]) && !rst;
            tick();
            if (!hold_sw) begin
                sw_req_valid = ($urandom_range(0, 99) < 35);
                sw_word_in   = $urandom;
            end
            sb_req_valid = ($urandom_range(0, 99) < 30);
            sb_state_in  = {$urandom, $urandom, $urandom, $urandom};
            rst          = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; sw_req_valid = 1'b0; sb_req_valid = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("rand_saw_responses", sb_resp_cnt[0] > 20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
